// File: rtl/mem_arbiter_rr_if.sv
// mem_arbiter_rr_if: requester-side and memory-side bus bundle
// for the N-port round-robin memory arbiter.
interface mem_arbiter_rr_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  localparam int IDX_WIDTH =
    (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]            req_read;
  logic [NUM_PORTS-1:0]            req_write;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_PORTS-1:0]            req_resp;
  logic [DATA_WIDTH-1:0]           req_rdata;
  logic                            mem_read;
  logic                            mem_write;
  logic [ADDR_WIDTH-1:0]           mem_address;
  logic [DATA_WIDTH-1:0]           mem_wdata;
  logic                            mem_resp;
  logic [DATA_WIDTH-1:0]           mem_rdata;
  logic                            busy;
  logic [IDX_WIDTH-1:0]            grant_idx;

  modport master (
    input  req_read, req_write, req_addr, req_wdata,
    input  mem_resp, mem_rdata,
    output req_resp, req_rdata,
    output mem_read, mem_write, mem_address, mem_wdata,
    output busy, grant_idx
  );

  modport slave (
    output req_read, req_write, req_addr, req_wdata,
    output mem_resp, mem_rdata,
    input  req_resp, req_rdata,
    input  mem_read, mem_write, mem_address, mem_wdata,
    input  busy, grant_idx
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-port round-robin arbiter onto one memory port.
// Define MEM_ARB_PORT0_PRIORITY_EN to give port 0 absolute priority.
module mem_arbiter_rr #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input logic              clk,
  input logic              rst_n,
  mem_arbiter_rr_if.master bus
);
  localparam int IDX_WIDTH =
    (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state, state_n;
  logic [IDX_WIDTH-1:0]   last_grant, last_grant_n;
  logic [IDX_WIDTH-1:0]   grant_idx, grant_idx_n;
  logic [IDX_WIDTH-1:0]   sel_idx;
  logic                   sel_found;
  logic                   cmd_read, cmd_read_n;
  logic                   cmd_write, cmd_write_n;
  logic [ADDR_WIDTH-1:0]  cmd_addr, cmd_addr_n;
  logic [DATA_WIDTH-1:0]  cmd_wdata, cmd_wdata_n;
  logic [NUM_PORTS-1:0]   reqs, rr_reqs;
  logic [ADDR_WIDTH-1:0]  addr_a  [NUM_PORTS];
  logic [DATA_WIDTH-1:0]  wdata_a [NUM_PORTS];

  assign reqs = bus.req_read | bus.req_write;

`ifdef MEM_ARB_PORT0_PRIORITY_EN
  assign rr_reqs = reqs & ~NUM_PORTS'(1);
`else
  assign rr_reqs = reqs;
`endif

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign addr_a[i]  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[i] = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan from the port after the last winner, wrapping around.
  always_comb begin
    logic [IDX_WIDTH-1:0] p;
    p         = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      p = IDX_WIDTH'((int'(last_grant) + k) % NUM_PORTS);
      if (!sel_found && rr_reqs[p]) begin
        sel_found = 1'b1;
        sel_idx   = p;
      end
    end
`ifdef MEM_ARB_PORT0_PRIORITY_EN
    if (reqs[0]) begin
      sel_found = 1'b1;
      sel_idx   = '0;
    end
`endif
  end

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    grant_idx_n  = grant_idx;
    cmd_read_n   = cmd_read;
    cmd_write_n  = cmd_write;
    cmd_addr_n   = cmd_addr;
    cmd_wdata_n  = cmd_wdata;
    bus.req_resp = '0;
    unique case (state)
      IDLE: begin
        if (sel_found) begin
          state_n     = BUSY;
          grant_idx_n = sel_idx;
          cmd_write_n = bus.req_write[sel_idx];
          cmd_read_n  = bus.req_read[sel_idx] &
                        ~bus.req_write[sel_idx];
          cmd_addr_n  = addr_a[sel_idx];
          cmd_wdata_n = wdata_a[sel_idx];
        end
      end
      BUSY: begin
        if (bus.mem_resp) begin
          bus.req_resp[grant_idx] = rst_n;
          state_n = IDLE;
`ifdef MEM_ARB_PORT0_PRIORITY_EN
          if (grant_idx != '0) last_grant_n = grant_idx;
`else
          last_grant_n = grant_idx;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= IDX_WIDTH'(NUM_PORTS - 1);
      grant_idx  <= '0;
      cmd_read   <= 1'b0;
      cmd_write  <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      grant_idx  <= grant_idx_n;
      cmd_read   <= cmd_read_n;
      cmd_write  <= cmd_write_n;
      cmd_addr   <= cmd_addr_n;
      cmd_wdata  <= cmd_wdata_n;
    end
  end

  assign bus.busy        = (state == BUSY);
  assign bus.mem_read    = (state == BUSY) & cmd_read;
  assign bus.mem_write   = (state == BUSY) & cmd_write;
  assign bus.mem_address = cmd_addr;
  assign bus.mem_wdata   = cmd_wdata;
  assign bus.grant_idx   = grant_idx;
  assign bus.req_rdata   = bus.mem_rdata;
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: directed + random checks of mem_arbiter_rr
// against a transaction-level round-robin model.
module tb_mem_arbiter_rr;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_rr_if #(
    .NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) bus ();

  mem_arbiter_rr #(
    .NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int total = 0;
  int bad = 0;

  bit             m_busy = 1'b0;
  int             m_last = N - 1;
  int             m_gidx = 0;
  bit             m_rd = 1'b0;
  bit             m_wr = 1'b0;
  logic [AW-1:0]  m_addr = '0;
  logic [DW-1:0]  m_wd = '0;
  int             grants[$];
  bit             pend[N];

`ifdef MEM_ARB_PORT0_PRIORITY_EN
  int rr_exp[5] = '{0, 0, 0, 0, 0};
`else
  int rr_exp[5] = '{0, 1, 2, 3, 0};
`endif

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Winner = requesting port with the smallest rotational
  // distance past the last winner.
  function automatic int pick(logic [N-1:0] r, int last);
    int best = -1;
    int bd = 2 * N;
    for (int p = 0; p < N; p++) begin
      if (r[p]) begin
        int d;
        d = (p - last - 1 + 2 * N) % N;
`ifdef MEM_ARB_PORT0_PRIORITY_EN
        if (p == 0) d = -1;
`endif
        if (d < bd) begin
          bd = d;
          best = p;
        end
      end
    end
    return best;
  endfunction

  task automatic model_edge();
    int p;
    if (!rst_n) begin
      m_busy = 1'b0; m_last = N - 1; m_gidx = 0;
      m_rd = 1'b0; m_wr = 1'b0; m_addr = '0; m_wd = '0;
    end else if (!m_busy) begin
      p = pick(bus.req_read | bus.req_write, m_last);
      if (p >= 0) begin
        m_busy = 1'b1;
        m_gidx = p;
        m_wr = bus.req_write[p];
        m_rd = bus.req_read[p] & ~bus.req_write[p];
        m_addr = bus.req_addr[p*AW +: AW];
        m_wd = bus.req_wdata[p*DW +: DW];
        grants.push_back(p);
      end
    end else if (bus.mem_resp) begin
`ifdef MEM_ARB_PORT0_PRIORITY_EN
      if (m_gidx != 0) m_last = m_gidx;
`else
      m_last = m_gidx;
`endif
      pend[m_gidx] = 1'b0;
      m_busy = 1'b0;
    end
  endtask

  // Inputs are set at the negedge before calling.
  task automatic cycle();
    logic [N-1:0] er;
    #1;
    er = '0;
    if (m_busy && bus.mem_resp && rst_n) er[m_gidx] = 1'b1;
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("mem_read", 32'(bus.mem_read), 32'(m_busy & m_rd));
    chk("mem_write", 32'(bus.mem_write), 32'(m_busy & m_wr));
    chk("req_resp", 32'(bus.req_resp), 32'(er));
    if (m_busy) begin
      chk("mem_address", 32'(bus.mem_address), 32'(m_addr));
      chk("grant_idx", 32'(bus.grant_idx), 32'(m_gidx));
      if (m_wr) chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_wd));
    end
    if (er != '0)
      chk("req_rdata", 32'(bus.req_rdata), 32'(bus.mem_rdata));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    bus.req_read = '0;
    bus.req_write = '0;
  endtask

  task automatic drain();
    clear_reqs();
    for (int i = 0; i < 3; i++) begin
      bus.mem_resp = m_busy;
      cycle();
    end
    bus.mem_resp = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic run_1cyc_mem(int n);
    for (int i = 0; i < n; i++) begin
      bus.mem_resp = m_busy;
      cycle();
    end
  endtask

  initial begin
    bus.req_read = '0;
    bus.req_write = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.mem_resp = 1'b0;
    bus.mem_rdata = '0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;

    // reset then idle, with a stray mem_resp
    @(negedge clk);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cycle();
    rst_n = 1'b1;
    bus.mem_resp = 1'b1;
    cycle();
    bus.mem_resp = 1'b0;
    chk("rst_addr", 32'(bus.mem_address), 32'h0);
    chk("rst_wdata", 32'(bus.mem_wdata), 32'h0);
    chk("rst_gidx", 32'(bus.grant_idx), 32'h0);
    chk("rst_resp", 32'(bus.req_resp), 32'h0);

    // single read from port 1, 3-cycle memory
    bus.req_read = 4'b0010;
    bus.req_addr[1*AW +: AW] = 16'h3000;
    cycle();
    cycle();
    cycle();
    bus.mem_resp = 1'b1;
    bus.mem_rdata = 16'hBEEF;
    #1;
    chk("single_rd", 32'(bus.mem_read), 32'h1);
    chk("single_addr", 32'(bus.mem_address), 32'h3000);
    chk("single_resp", 32'(bus.req_resp), 32'h2);
    chk("single_rdata", 32'(bus.req_rdata), 32'hBEEF);
    cycle();
    clear_reqs();
    bus.mem_resp = 1'b0;
    #1;
    chk("single_gap", 32'(bus.mem_read), 32'h0);
    cycle();

    // fairness with all ports requesting
    do_reset();
    grants.delete();
    bus.req_read = 4'b1111;
    run_1cyc_mem(10);
    chk("rr_count", 32'(grants.size() >= 5), 32'h1);
    for (int i = 0; i < 5 && i < grants.size(); i++)
      chk($sformatf("rr_seq%0d", i), 32'(grants[i]),
          32'(rr_exp[i]));
    drain();

    // read+write on one port: write wins
    bus.req_read = 4'b0001;
    bus.req_write = 4'b0001;
    bus.req_addr[0 +: AW] = 16'h0040;
    bus.req_wdata[0 +: DW] = 16'h1234;
    cycle();
    #1;
    chk("wp_write", 32'(bus.mem_write), 32'h1);
    chk("wp_read", 32'(bus.mem_read), 32'h0);
    chk("wp_wdata", 32'(bus.mem_wdata), 32'h1234);
    bus.mem_resp = 1'b1;
    cycle();
    drain();

    // early drop: snapshot still completes
    bus.req_read = 4'b0001;
    bus.req_addr[0 +: AW] = 16'h0100;
    cycle();
    clear_reqs();
    #1;
    chk("drop_rd", 32'(bus.mem_read), 32'h1);
    chk("drop_addr", 32'(bus.mem_address), 32'h0100);
    cycle();
    bus.mem_resp = 1'b1;
    #1;
    chk("drop_resp", 32'(bus.req_resp), 32'h1);
    cycle();
    bus.mem_resp = 1'b0;
    cycle();

    // reset while BUSY abandons the transaction
    bus.req_read = 4'b0100;
    bus.req_addr[2*AW +: AW] = 16'h0200;
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    clear_reqs();
    #1;
    chk("rstb_busy", 32'(bus.busy), 32'h0);
    chk("rstb_resp", 32'(bus.req_resp), 32'h0);
    chk("rstb_addr", 32'(bus.mem_address), 32'h0);
    cycle();

`ifdef MEM_ARB_PORT0_PRIORITY_EN
    do_reset();
    grants.delete();
    bus.req_read = 4'b0101;
    run_1cyc_mem(8);
    for (int i = 0; i < grants.size(); i++)
      chk("pri_p0", 32'(grants[i]), 32'h0);
    drain();
    do_reset();
    grants.delete();
    bus.req_read = 4'b1110;
    run_1cyc_mem(6);
    chk("pri_cnt", 32'(grants.size()), 32'd3);
    for (int i = 0; i < 3 && i < grants.size(); i++)
      chk("pri_rot", 32'(grants[i]), 32'(i + 1));
    drain();
`endif

    // random traffic
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int p = 0; p < N; p++) begin
        if (!pend[p]) begin
          if ($urandom_range(3) == 0) begin
            pend[p] = 1'b1;
            bus.req_write[p] = 1'($urandom_range(1));
            bus.req_read[p] = bus.req_write[p] ?
                              1'($urandom_range(1)) : 1'b1;
            bus.req_addr[p*AW +: AW] = AW'($urandom);
            bus.req_wdata[p*DW +: DW] = DW'($urandom);
          end else begin
            bus.req_read[p] = 1'b0;
            bus.req_write[p] = 1'b0;
          end
        end
      end
      bus.mem_resp = m_busy ? ($urandom_range(2) == 0)
                            : ($urandom_range(7) == 0);
      bus.mem_rdata = DW'($urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Parametrised N-port round-robin arbiter between LC-3b datapath requesters (instruction fetch, data memory, and others) and a single shared memory port.
- Latches one requester's command, holds it on the memory bus until mem_resp, then returns the response to that requester only.
- Replaces the fixed two-port fetch/mem arbiter: arbitrary port count, fairness rotation, write data path and a mem_resp handshake.

Parameters:
- NUM_PORTS, 2, number of requester ports (2..8)
- ADDR_WIDTH, 16, address width (lc3b_word)
- DATA_WIDTH, 16, read/write data width
- IDX_WIDTH, $clog2(NUM_PORTS) (min 1), grant index width; derived, not overridden

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- req_read  in  NUM_PORTS  per-port read request
- req_write  in  NUM_PORTS  per-port write request
- req_addr  in  NUM_PORTS*ADDR_WIDTH  packed per-port addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_PORTS*DATA_WIDTH  packed per-port write data
- req_resp  out  NUM_PORTS  one-hot completion pulse to the granted port
- req_rdata  out  DATA_WIDTH  mem_rdata broadcast; valid only with req_resp
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_address  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_resp  in  1  memory completion, single-cycle pulse
- mem_rdata  in  DATA_WIDTH  memory read data
- busy  out  1  high while a transaction is outstanding
- grant_idx  out  IDX_WIDTH  index of the port currently being served

Behaviour:
- States: IDLE, BUSY.
- Reset values:
  - state=IDLE, last_grant=NUM_PORTS-1, so port 0 has first priority.
  - mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, req_resp=0, busy=0, grant_idx=0.
- A port is requesting when req_read[i] | req_write[i].
- IDLE:
  - All mem strobes are 0.
  - If any port is requesting, select the first requesting port scanning from last_grant+1 upward, wrapping modulo NUM_PORTS.
  - On that edge: register grant_idx and a command snapshot (read, write, addr, wdata), then go to BUSY.
  - If no port is requesting, stay in IDLE.
- Latency: a request sampled at edge T gives mem strobes high in cycle T+1 (one registered cycle).
- BUSY:
  - mem_read/mem_write/mem_address/mem_wdata are driven from the snapshot, not live inputs, and held stable until mem_resp.
  - busy=1.
  - When mem_resp=1: req_resp[grant_idx]=1 combinationally in the same cycle and req_rdata=mem_rdata. On that edge, last_grant<=grant_idx and state<=IDLE.
- Gap between transactions: there is at least one IDLE cycle between transactions, with strobes low. This gives a clean strobe edge for the memory model.
- Read and write both set on one port: write wins; mem_read=0 for that transaction.
- Requester rules:
  - A requester holds its request until its req_resp. Dropping it early does not abort the transaction; the snapshot completes.
  - A request still held after its own req_resp is treated as a new request at the next arbitration.
- mem_resp while IDLE: ignored; no req_resp is raised.
- Reset asserted in BUSY: return to IDLE next edge with outputs at reset values. The in-flight transaction is abandoned with no req_resp.
- Fairness: with all ports requesting continuously, the grant order is 0,1,...,N-1,0,... Each port waits at most N-1 transactions.

Optional Feature:
- Macro MEM_ARB_PORT0_PRIORITY_EN.
- Defined: port 0 (instruction fetch) wins any IDLE arbitration in which it is requesting. The remaining ports rotate round-robin among themselves; last_grant is not updated when port 0 is granted.
- Undefined: pure round-robin as described in Behaviour.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, no requests, mem_resp pulsed -> all outputs 0, req_resp=0, busy=0.
- Single read: port 1 req_read, addr 16'h3000; memory answers after 3 cycles with rdata 16'hBEEF -> mem_read high from T+1, mem_address=3000 held, req_resp=2'b10 with req_rdata=BEEF in the mem_resp cycle, then one IDLE cycle.
- Round-robin, NUM_PORTS=4: all ports request reads continuously, 1-cycle memory -> grant_idx sequence 0,1,2,3,0.
- Write priority: port 0 asserts read and write, addr 16'h0040, wdata 16'h1234 -> mem_write=1, mem_read=0, mem_wdata=1234.
- Early drop and reset: port 0 drops its request while BUSY -> snapshot completes and req_resp[0] pulses. Reset asserted mid-BUSY on a second transaction -> IDLE next cycle with no req_resp.
- With MEM_ARB_PORT0_PRIORITY_EN, ports 0 and 2 both requesting continuously -> port 0 granted every time. Port 0 idle -> grants rotate 1,2,3.
